// File: rtl/csa_stream_accumulator_if.sv
// Stream interface for csa_stream_accumulator: operand input channel and
// binary result output channel, each with a valid/ready handshake.
// The slave modport is the accumulator; the master modport is its environment
// (operand producer plus result consumer).
interface csa_stream_accumulator_if #(
  parameter int W     = 4,
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: sums a frame of unsigned operands into a redundant
// (sum, carry) register pair, one full-adder delay per beat, then resolves the
// pair into a binary total RES_BITS bits per cycle and offers it downstream.
// Optional build macro CSA_ACC_OVF_DETECT_EN adds the sticky overflow flag;
// without it out_ovf is tied low and the total simply wraps modulo 2^ACC_W.
module csa_stream_accumulator #(
  parameter int W        = 4,
  parameter int ACC_W    = 12,
  parameter int RES_BITS = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  csa_stream_accumulator_if.slave bus
);

  localparam int N     = ACC_W / RES_BITS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [ACC_W-1:0]    s_r;
  logic [ACC_W-1:0]    c_r;
  logic [ACC_W-1:0]    res_r;
  logic [7:0]          count_r;
  logic [IDX_W-1:0]    idx_r;
  logic                carry_r;
  logic                in_ready_r;
  logic                out_valid_r;

  logic                accept_s;
  logic                hs_s;
  logic                last_slice_s;
  logic [ACC_W-1:0]    x_s;
  logic [ACC_W-1:0]    s_acc_s;
  logic [ACC_W-2:0]    maj_lo_s;
  logic [ACC_W-1:0]    c_acc_s;
  logic [RES_BITS-1:0] s_slice_s;
  logic [RES_BITS-1:0] c_slice_s;
  logic [RES_BITS:0]   slice_sum_s;

  assign accept_s     = bus.in_valid & in_ready_r;
  assign hs_s         = out_valid_r & bus.out_ready;
  assign last_slice_s = (idx_r == IDX_W'(N - 1));

  // One carry-save step: sum bits take the 3-way XOR, carries the shifted majority.
  // The majority at the MSB position leaves the word and is handled only by overflow detection.
  assign x_s      = {{(ACC_W - W){1'b0}}, bus.in_data};
  assign s_acc_s  = s_r ^ c_r ^ x_s;
  assign maj_lo_s = (s_r[ACC_W-2:0] & c_r[ACC_W-2:0]) |
                    (s_r[ACC_W-2:0] & x_s[ACC_W-2:0]) |
                    (c_r[ACC_W-2:0] & x_s[ACC_W-2:0]);
  assign c_acc_s  = {maj_lo_s, 1'b0};

  // Carry-propagate slice for the current resolve index, LSB slice first.
  assign s_slice_s   = s_r[int'(idx_r) * RES_BITS +: RES_BITS];
  assign c_slice_s   = c_r[int'(idx_r) * RES_BITS +: RES_BITS];
  assign slice_sum_s = {1'b0, s_slice_s} + {1'b0, c_slice_s} + {{RES_BITS{1'b0}}, carry_r};

  // State register of the accumulate / resolve / present controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: last beat starts resolve, final slice presents, handshake rearms.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && bus.in_last) begin
          state_next_s = RESOLVE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      RESOLVE: begin
        if (last_slice_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RESOLVE;
        end
      end
      DONE: begin
        if (hs_s) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = ACCUM;
    endcase
  end

  // Datapath: carry-save accumulation, slice-wise resolve, clear on result handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_r     <= {ACC_W{1'b0}};
      c_r     <= {ACC_W{1'b0}};
      res_r   <= {ACC_W{1'b0}};
      count_r <= 8'd0;
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            s_r <= s_acc_s;
            c_r <= c_acc_s;
            if (count_r != 8'd255) begin
              count_r <= count_r + 8'd1;
            end
          end
        end
        RESOLVE: begin
          res_r[int'(idx_r) * RES_BITS +: RES_BITS] <= slice_sum_s[RES_BITS-1:0];
          if (last_slice_s) begin
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
          end else begin
            idx_r   <= idx_r + {{(IDX_W - 1){1'b0}}, 1'b1};
            carry_r <= slice_sum_s[RES_BITS];
          end
        end
        DONE: begin
          if (hs_s) begin
            s_r     <= {ACC_W{1'b0}};
            c_r     <= {ACC_W{1'b0}};
            count_r <= 8'd0;
          end
        end
        default: begin
          idx_r   <= {IDX_W{1'b0}};
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered handshake outputs; out_valid trails entry into DONE by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == ACCUM);
      out_valid_r <= (state_r == DONE) && !hs_s;
    end
  end

`ifdef CSA_ACC_OVF_DETECT_EN
  logic sticky_r;
  logic out_ovf_r;

  // Sticky overflow: any carry lost from the carry word's MSB or out of the final slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_r  <= 1'b0;
      out_ovf_r <= 1'b0;
    end else begin
      out_ovf_r <= (state_r == DONE) && !hs_s && sticky_r;
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            sticky_r <= sticky_r | ((s_r[ACC_W-1] & c_r[ACC_W-1]) |
                                    (s_r[ACC_W-1] & x_s[ACC_W-1]) |
                                    (c_r[ACC_W-1] & x_s[ACC_W-1]));
          end
        end
        RESOLVE: begin
          if (last_slice_s) begin
            sticky_r <= sticky_r | slice_sum_s[RES_BITS];
          end
        end
        DONE: begin
          if (hs_s) begin
            sticky_r <= 1'b0;
          end
        end
        default: sticky_r <= 1'b0;
      endcase
    end
  end

  assign bus.out_ovf = out_ovf_r;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = res_r;
  assign bus.out_count = count_r;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench for csa_stream_accumulator. Expected totals come from
// plain integer addition over each frame; randomized inter-beat gaps and
// random frames exercise the handshake. Honours CSA_ACC_OVF_DETECT_EN.
module tb_csa_stream_accumulator;
  logic clk = 1'b0;
  logic rst_n;

  int errors = 0;
  int checks = 0;
  int frame_q[$];
  int exp_total;
  int exp_n;

  csa_stream_accumulator_if #(.W(4), .ACC_W(12)) ifc ();

  csa_stream_accumulator #(.W(4), .ACC_W(12), .RES_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive every entry of frame_q as one frame, in_last on the final entry.
  task automatic send_frame(input int gap_max);
    exp_total = 0;
    exp_n     = frame_q.size();
    foreach (frame_q[i]) begin
      exp_total += frame_q[i];
      repeat ($urandom_range(0, gap_max)) begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = 4'($urandom);
        ifc.in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = 4'(frame_q[i]);
      ifc.in_last  = (i == exp_n - 1);
      begin
        int w = 0;
        while (ifc.in_ready !== 1'b1 && w < 200) begin
          @(posedge clk); #1;
          w++;
        end
        if (w >= 200) chk("beat_accept_timeout", 32'(w), 32'd0);
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  // Wait for the result, compare with the arithmetic model, optionally stall, then handshake.
  task automatic expect_result(input string tag, input int hold);
    int k = 0;
    int exp_sum = exp_total % 4096;
    int exp_cnt = (exp_n > 255) ? 255 : exp_n;
    int exp_ovf;
`ifdef CSA_ACC_OVF_DETECT_EN
    exp_ovf = (exp_total >= 4096) ? 1 : 0;
`else
    exp_ovf = 0;
`endif
    while (ifc.out_valid !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd4);
    chk({tag, "_sum"}, 32'(ifc.out_sum), 32'(exp_sum));
    chk({tag, "_count"}, 32'(ifc.out_count), 32'(exp_cnt));
    chk({tag, "_ovf"}, 32'(ifc.out_ovf), 32'(exp_ovf));
    repeat (hold) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 4'd7;
      ifc.in_last  = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(ifc.out_valid), 32'd1);
      chk({tag, "_hold_sum"}, 32'(ifc.out_sum), 32'(exp_sum));
      chk({tag, "_hold_ready"}, 32'(ifc.in_ready), 32'd0);
    end
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(ifc.out_valid), 32'd0);
    chk({tag, "_rearm"}, 32'(ifc.in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = 4'd0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_sum", 32'(ifc.out_sum), 32'd0);
    chk("rst_out_count", 32'(ifc.out_count), 32'd0);
    chk("rst_out_ovf", 32'(ifc.out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // Basic frame and latency
    frame_q = '{3, 5, 7};
    send_frame(0);
    expect_result("f357", 0);

    // Single-beat frame of zero
    frame_q = '{0};
    send_frame(0);
    expect_result("single0", 0);

    // Long frame: count saturates, total wraps
    frame_q.delete();
    repeat (300) frame_q.push_back(15);
    send_frame(0);
    expect_result("long300", 0);

    // Back-pressure on the result, then a clean follow-on frame
    frame_q = '{9, 9};
    send_frame(0);
    expect_result("hold99", 5);
    frame_q = '{1, 2};
    send_frame(0);
    expect_result("after_hold", 0);

    // Idle gaps between beats
    frame_q = '{4, 4, 4, 4};
    send_frame(3);
    expect_result("gaps4", 0);

    // Reset during resolve discards the frame
    frame_q = '{15, 15};
    send_frame(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_sum", 32'(ifc.out_sum), 32'd0);
    chk("midrst_count", 32'(ifc.out_count), 32'd0);
    chk("midrst_ovf", 32'(ifc.out_ovf), 32'd0);
    @(posedge clk); #1;
    chk("midrst_ready", 32'(ifc.in_ready), 32'd1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("midrst_no_emit", 32'(ifc.out_valid), 32'd0);
    end
    frame_q = '{2};
    send_frame(0);
    expect_result("post_rst", 0);

    // Random frames, some long enough to overflow
    for (int f = 0; f < 4; f++) begin
      int len = $urandom_range(1, 450);
      frame_q.delete();
      repeat (len) frame_q.push_back(int'($urandom_range(0, 15)));
      send_frame(2);
      expect_result($sformatf("rand%0d", f), f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential consumer of the team's carry-save arithmetic. Accepts a stream of W-bit unsigned operands over a valid/ready handshake.
- Accumulates each operand into a redundant (sum, carry) register pair with no carry propagation per beat, so each beat costs one full-adder delay.
- On the frame's last beat, runs a multi-cycle carry-propagate resolve and presents the binary total on a valid/ready output.
- Sits downstream of operand producers; feeds binary results to the datapath.

Parameters:
- W, 4, input operand width.
- ACC_W, 12, accumulator and result width; must be ≥ W+1.
- RES_BITS, 4, bits resolved per cycle in the carry-propagate phase; ACC_W must be divisible by RES_BITS.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  W  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  operand is the final one of the frame; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  binary total modulo 2^ACC_W.
- out_count  output  8  number of operands in the frame, saturating at 255.
- out_ovf  output  1  true total ≥ 2^ACC_W; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to ACCUM.
  - S, C, count, the resolve index and the ovf sticky all clear.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready becomes 1 in the first cycle after reset is released.
  - Reset applied mid-frame, mid-resolve or while holding a result discards everything; nothing is emitted.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESOLVE: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- ACCUM, on an accepted beat (in_valid & in_ready):
  - For each bit i: S'[i] = S[i]^C[i]^x[i]; C'[i+1] = maj(S[i],C[i],x[i]); C'[0] = 0.
  - The majority bit at position ACC_W-1 is shifted out and lost from C.
  - count increments, saturating at 255.
  - If in_last=1 on that beat, the next state is RESOLVE.
  - in_valid=0 leaves all state unchanged.
- RESOLVE:
  - Each cycle adds RES_BITS bits of S and C plus a running carry, starting from the LSB slice; result bits are written into a result register.
  - Runs for N = ACC_W/RES_BITS cycles; the final carry-out is dropped from out_sum.
  - Then moves to DONE.
- Latency: last beat accepted at edge T → out_valid=1 from edge T+N+1 (defaults: N=3).
- DONE:
  - out_sum, out_count and out_ovf stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: S, C, count and sticky clear, and the state returns to ACCUM.
  - in_ready=1 in the cycle after the handshake, so there is one bubble between frames.
- Boundaries:
  - A single-beat frame is legal.
  - An empty frame is impossible, because in_last is only sampled with valid data.
  - in_last is ignored when in_valid=0.
  - in_valid asserted during RESOLVE or DONE is not accepted; the producer must hold the beat until in_ready.

Optional Feature:
- Macro: CSA_ACC_OVF_DETECT_EN.
- With the macro defined:
  - A sticky bit sets whenever a majority bit is shifted out of C's MSB during ACCUM, or when the final RESOLVE carry-out is 1.
  - out_ovf = sticky in DONE.
  - The sticky is exact for unsigned inputs: out_ovf=1 iff the true total ≥ 2^ACC_W.
- Without the macro: out_ovf is tied to 0 and no sticky logic is built. out_sum still wraps modulo 2^ACC_W.

Test Plan:
- Frame 3, 5, 7 (last on 7), out_ready=1 → out_sum=15, out_count=3, out_ovf=0; out_valid rises exactly 4 cycles after the last-beat edge.
- Single beat 0 with in_last=1 → out_sum=0, out_count=1, out_ovf=0.
- 300 beats of 15 (last on 300th), macro defined → out_sum=404, out_count=255, out_ovf=1. Same stimulus without the macro → out_sum=404, out_ovf=0.
- Frame 9, 9 with out_ready held 0 for 5 cycles → out_valid=1 and out_sum=18 stable throughout, in_ready=0. On release, one handshake, then in_ready=1 the next cycle. A new frame 1, 2 → 3 with no carryover.
- Random in_valid gaps inside the frame 4, 4, 4, 4 → out_sum=16, out_count=4; idle cycles don't change state.
- rst_n=0 for one edge during RESOLVE of frame 15, 15 → no out_valid, outputs 0, in_ready=1 after release. The next frame 2 (last) → out_sum=2, out_count=1.
